// File: rtl/reaction_judge.sv
// Reaction-time judge: launches a round, then times the player's key press against the
// generator's target LED and posts hit/miss, early, or timeout with the elapsed ms.
module reaction_judge #(
    parameter int unsigned CLK_PER_MS = 50000,
    parameter int unsigned TIMEOUT_MS = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        det_start,
    input  logic [7:0]  led,
    input  logic [7:0]  key,
    input  logic        start_key,
    output logic        restart,
    output logic        busy,
    output logic [13:0] react_ms,
    output logic        result_valid,
    output logic        hit,
    output logic        early,
    output logic        timeout
);

    localparam int unsigned DivW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    typedef enum logic [1:0] {StIdle, StArmed, StMeasure, StDone} state_e;

    state_e state_q, state_d;

    logic [7:0]      key_q, target_q;
    logic            start_key_q;
    logic [DivW-1:0] div_cnt_q;
    logic [13:0]     ms_cnt_q, react_ms_q;
    logic            restart_q, result_valid_q, hit_q, early_q, timeout_q;

    logic [7:0] press;
    logic       go, tick, last_ms;

    assign press   = key & ~key_q;
    assign go      = start_key & ~start_key_q;
    assign tick    = (div_cnt_q == DivW'(CLK_PER_MS - 1));
    assign last_ms = (ms_cnt_q == 14'(TIMEOUT_MS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (go) state_d = StArmed;
            StArmed: begin
                // det_start outranks a same-cycle press
                if (det_start)         state_d = StMeasure;
                else if (press != '0)  state_d = StDone;
            end
            StMeasure: if ((press != '0) || (tick && last_ms)) state_d = StDone;
            StDone:    if (go) state_d = StArmed;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StArmed) || (state_q == StMeasure);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q          <= '0;
            start_key_q    <= 1'b0;
            target_q       <= '0;
            div_cnt_q      <= '0;
            ms_cnt_q       <= '0;
            react_ms_q     <= '0;
            restart_q      <= 1'b0;
            result_valid_q <= 1'b0;
            hit_q          <= 1'b0;
            early_q        <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            key_q          <= key;
            start_key_q    <= start_key;
            restart_q      <= 1'b0;
            result_valid_q <= 1'b0;

            if (((state_q == StArmed) && det_start) || tick) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + DivW'(1);
            end

            unique case (state_q)
                StIdle, StDone: begin
                    if (go) begin
                        restart_q  <= 1'b1;
                        hit_q      <= 1'b0;
                        early_q    <= 1'b0;
                        timeout_q  <= 1'b0;
                        react_ms_q <= '0;
                    end
                end
                StArmed: begin
                    if (det_start) begin
                        target_q <= led;
                        ms_cnt_q <= '0;
                    end else if (press != '0) begin
                        early_q        <= 1'b1;
                        hit_q          <= 1'b0;
                        react_ms_q     <= '0;
                        result_valid_q <= 1'b1;
                    end
                end
                StMeasure: begin
                    if (tick) ms_cnt_q <= ms_cnt_q + 14'd1;
                    // A press in the final-tick cycle wins over timeout
                    if (press != '0) begin
                        hit_q          <= (press == target_q);
                        react_ms_q     <= ms_cnt_q;
                        result_valid_q <= 1'b1;
                    end else if (tick && last_ms) begin
                        timeout_q      <= 1'b1;
                        hit_q          <= 1'b0;
                        react_ms_q     <= 14'(TIMEOUT_MS);
                        result_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign restart      = restart_q;
    assign react_ms     = react_ms_q;
    assign result_valid = result_valid_q;
    assign hit          = hit_q;
    assign early        = early_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_judge.sv
// Scoreboard bench for reaction_judge: each round pushes its expected result and the
// result monitor pops and compares whenever result_valid pulses.
module tb_reaction_judge;

    localparam int unsigned CLK_PER_MS = 10;
    localparam int unsigned TIMEOUT_MS = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        det_start = 1'b0;
    logic [7:0]  led = '0;
    logic [7:0]  key = '0;
    logic        start_key = 1'b0;
    logic        restart, busy, result_valid, hit, early, timeout;
    logic [13:0] react_ms;

    reaction_judge #(
        .CLK_PER_MS(CLK_PER_MS),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .det_start    (det_start),
        .led          (led),
        .key          (key),
        .start_key    (start_key),
        .restart      (restart),
        .busy         (busy),
        .react_ms     (react_ms),
        .result_valid (result_valid),
        .hit          (hit),
        .early        (early),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        early;
        logic        timeout;
        logic [13:0] ms;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_result_valid", 32'(result_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("hit", 32'(hit), 32'(e.hit));
                check_eq("early", 32'(early), 32'(e.early));
                check_eq("timeout", 32'(timeout), 32'(e.timeout));
                check_eq("react_ms", 32'(react_ms), 32'(e.ms));
                check_eq("result_cycle", 32'(cyc), 32'(e.cyc));
                check_eq("busy_at_result", 32'(busy), 32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic h, input logic e, input logic t, input int ms, input int c);
        exp_t x;
        x.hit = h; x.early = e; x.timeout = t; x.ms = 14'(ms); x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            check_eq("result_wait_expired", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic start_round();
        start_key = 1'b1;
        step(1);
        start_key = 1'b0;
        @(negedge clk);
        check_eq("restart_pulse", 32'(restart), 32'd1);
        check_eq("busy_armed", 32'(busy), 32'd1);
        check_eq("results_cleared", {17'd0, hit, early, timeout, react_ms}, 32'd0);
        step(1);
        @(negedge clk);
        check_eq("restart_one_cycle", 32'(restart), 32'd0);
        step(1);
    endtask

    task automatic det(input logic [7:0] pattern, output int dcyc);
        det_start = 1'b1;
        led = pattern;
        dcyc = cyc;
        step(1);
        det_start = 1'b0;
        led = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {16'd0, restart, busy, result_valid, hit, early, timeout, react_ms}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, r;

        // Reset state
        step(3);
        @(negedge clk);
        check_all_zero("reset_outputs");
        step(1);
        rst_n = 1'b1;
        step(2);
        @(negedge clk);
        check_all_zero("idle_outputs");
        step(1);

        // Hit at 23 ms
        start_round();
        det(8'h10, d);
        step(236);
        key = 8'h10;
        push(1'b1, 1'b0, 1'b0, 23, d + 238);
        step(1);
        key = '0;
        wait_done(20);

        // Miss with wrong key
        start_round();
        det(8'h10, d);
        step(236);
        key = 8'h04;
        push(1'b0, 1'b0, 1'b0, 23, d + 238);
        step(1);
        key = '0;
        wait_done(20);

        // Early press; later det_start must be ignored
        start_round();
        step(3);
        key = 8'h01;
        push(1'b0, 1'b1, 1'b0, 0, cyc + 1);
        step(1);
        key = '0;
        wait_done(20);
        det(8'h01, d);
        step(30);
        @(negedge clk);
        check_eq("early_done_busy", 32'(busy), 32'd0);
        check_eq("early_held", 32'(early), 32'd1);
        step(1);

        // Timeout, 501 cycles after det_start
        start_round();
        det(8'h02, d);
        push(1'b0, 1'b0, 1'b1, TIMEOUT_MS, d + 501);
        wait_done(600);

        // Press on the final tick cycle wins over timeout
        start_round();
        det(8'h02, d);
        step(499);
        key = 8'h02;
        push(1'b1, 1'b0, 1'b0, TIMEOUT_MS - 1, d + 501);
        step(1);
        key = '0;
        wait_done(20);

        // Key held across det_start: nothing until release and re-press
        key = 8'h08;
        step(2);
        start_round();
        det(8'h08, d);
        step(100);
        @(negedge clk);
        check_eq("held_key_busy", 32'(busy), 32'd1);
        step(1);
        key = '0;
        step(1);
        key = 8'h08;
        r = cyc;
        push(1'b1, 1'b0, 1'b0, (r - d - 1) / int'(CLK_PER_MS), r + 1);
        step(1);
        key = '0;
        wait_done(20);

        // det_start and press in the same ARMED cycle: measure, not early
        start_round();
        key = 8'h20;
        det(8'h20, d);
        @(negedge clk);
        check_eq("same_cycle_measure_busy", 32'(busy), 32'd1);
        check_eq("same_cycle_not_early", 32'(early), 32'd0);
        push(1'b0, 1'b0, 1'b1, TIMEOUT_MS, d + 501);
        wait_done(600);
        key = '0;
        step(2);

        // Reset mid-MEASURE, then a clean round
        start_round();
        det(8'h01, d);
        step(50);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset_outputs");
        step(3);
        @(negedge clk);
        check_all_zero("held_reset_outputs");
        step(1);
        rst_n = 1'b1;
        step(2);
        start_round();
        det(8'h40, d);
        step(55);
        key = 8'h40;
        push(1'b1, 1'b0, 1'b0, 5, d + 57);
        step(1);
        key = '0;
        wait_done(20);

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_judge.md
# reaction_judge

Downstream stage of the LED pattern generator in the reaction-test design. It launches each round by pulsing `restart` to the generator. It then takes the generator's `det_start` pulse and `led` pattern and times the player's key response in milliseconds. It reports hit, miss, early press or timeout to the display stage.

## Interface
Parameters:
- `CLK_PER_MS`, 50000: clock cycles per millisecond tick.
- `TIMEOUT_MS`, 2000: maximum response window in ms. Legal range 1..9999.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `det_start`  in  1  one-cycle pulse from the generator; `led` is valid in the same cycle.
- `led`  in  8  target pattern (one-hot) from the generator.
- `key`  in  8  debounced player keys, active-high level, one bit per LED.
- `start_key`  in  1  debounced new-round request, active-high level.
- `restart`  out  1  one-cycle pulse to the generator.
- `busy`  out  1  high in states ARMED and MEASURE.
- `react_ms`  out  14  measured reaction time in ms; holds until the next round.
- `result_valid`  out  1  one-cycle pulse when a result is posted.
- `hit`  out  1  pressed key matches the target; level, holds.
- `early`  out  1  key pressed before `det_start`; level, holds.
- `timeout`  out  1  no press within `TIMEOUT_MS`; level, holds.

## Operation
- Edge detect: `key_q` and `start_key_q` are registered copies of the inputs.
  - `press = key & ~key_q` (new presses only; held keys are ignored).
  - `go = start_key & ~start_key_q`.
- Prescaler `div_cnt` counts 0..CLK_PER_MS-1 and wraps. `tick` is asserted at the terminal count.
- State IDLE (reset state):
  - On `go`: pulse `restart`, clear `hit`/`early`/`timeout`/`react_ms`, go to ARMED.
- State ARMED:
  - If `det_start`: latch `target <= led`, clear `div_cnt` and `ms_cnt`, go to MEASURE. `det_start` has priority over a same-cycle `press`.
  - Else if `press != 0`: `early <= 1`, `hit <= 0`, `react_ms <= 0`, pulse `result_valid`, go to DONE.
  - `go` is ignored in this state.
- State MEASURE:
  - Counting: on `tick`, `ms_cnt` increments (14 bits).
  - Press: if `press != 0`, set `hit <= (press == target)`. Exact match only; multiple simultaneous bits count as a miss. Set `react_ms <= ms_cnt`, pulse `result_valid`, go to DONE.
  - Timeout: else if `tick` and `ms_cnt == TIMEOUT_MS-1`, set `timeout <= 1`, `hit <= 0`, `react_ms <= TIMEOUT_MS`, pulse `result_valid`, go to DONE.
  - A press in the timeout cycle wins.
  - `go` is ignored in this state.
- State DONE:
  - Result outputs hold.
  - On `go`: same action as in IDLE (pulse `restart`, clear results, go to ARMED).
- `react_ms` reports whole elapsed ms, truncated.
- Reset mid-round: all state is cleared immediately. The generator is not reset by this block; the next `go` issues `restart`.

## Timing
- Reset values:
  - `restart`, `busy`, `result_valid`, `hit`, `early`, `timeout`: 0.
  - `react_ms`: 0.
  - `key_q`, `start_key_q`: 0, so a key held through reset release registers one press.
  - State: IDLE.
- `go` seen in cycle N → `restart` high in cycle N+1 only; `busy` high from N+1.
- `det_start` in cycle N → MEASURE from N+1, with `ms_cnt = 0` and `div_cnt = 0` at N+1.
- Press edge: `key` rising at the clock edge that starts cycle N → `press` seen in cycle N → `result_valid` and updated flags in cycle N+1.
- Latency from `det_start` to the timeout result: `TIMEOUT_MS*CLK_PER_MS + 1` cycles.
- `result_valid` is exactly one pulse per round, coincident with the first cycle of DONE.
- `busy` falls in the same cycle that `result_valid` rises.

## Test plan
Benches use `CLK_PER_MS=10`, `TIMEOUT_MS=50`.
- Reset, then `go`:
  - Expect `restart` pulse for one cycle, one cycle after `go`, with `busy=1`.
  - Then `det_start` with `led=8'h10`, then `key=8'h10` 237 cycles later.
  - Required: `hit=1`, `react_ms=23`, `result_valid` pulse, `busy=0`.
- Same round, but `key=8'h04`: required `hit=0`, `early=0`, `timeout=0`, `react_ms` per elapsed ms.
- Press `key=8'h01` in ARMED before `det_start`: required `early=1`, `react_ms=0`, state DONE; a later `det_start` is ignored.
- No key after `det_start`: required `timeout=1`, `react_ms=50`, `result_valid` exactly 501 cycles after `det_start`.
- Boundary cases:
  - Press on the same cycle as the final `tick`: required hit result, not timeout.
  - `key` held high across `det_start`: required no result until release and re-press.
  - `det_start` and a press in the same ARMED cycle: required entry to MEASURE, not early.
- Assert `rst_n=0` mid-MEASURE, release, then `go`: required all outputs 0 during reset, and a clean new round.
